// File: rtl/acc_frame.sv
// -----------------------------------------------------------------------------
// acc_frame
//
// Accumulates a frame of unsigned beats into a wrapping OUT_LEN-bit total and
// presents the frame result through a valid/ready handshake. A frame closes on
// an accepted beat with last=1, or on the accepted beat that brings the beat
// count to MAX_BEATS. While a result is held (DONE) the block stops accepting
// beats until the downstream consumer takes the result.
//
// Parameters
//   LEN        input beat width
//   OUT_LEN    accumulator / result width (OUT_LEN >= LEN)
//   MAX_BEATS  maximum beats per frame (>= 2)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   data       upstream beat, unsigned
//   valid      upstream beat present
//   last       final beat of the frame (qualified by valid)
//   ready      block accepts a beat this cycle (high in ACC)
//   sum        frame total, modulo 2^OUT_LEN
//   sum_valid  sum/beats/ovf hold a completed frame
//   sum_ready  downstream accepts the result
//   beats      number of beats in the completed frame
//   ovf        the frame total wrapped beyond OUT_LEN bits
// -----------------------------------------------------------------------------
module acc_frame #(
  parameter int LEN       = 8,
  parameter int OUT_LEN   = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LEN-1:0]                 data,
  input  logic                           valid,
  input  logic                           last,
  output logic                           ready,
  output logic [OUT_LEN-1:0]             sum,
  output logic                           sum_valid,
  input  logic                           sum_ready,
  output logic [$clog2(MAX_BEATS+1)-1:0] beats,
  output logic                           ovf
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Wrapping add of a zero-extended beat; the top bit of the result is the
  // carry out of bit OUT_LEN-1.
  function automatic logic [OUT_LEN:0] add_wrap(
    input logic [OUT_LEN-1:0] acc_in,
    input logic [LEN-1:0]     beat_in
  );
    logic [OUT_LEN:0] a_ext;
    logic [OUT_LEN:0] b_ext;
    a_ext = {1'b0, acc_in};
    b_ext = (OUT_LEN + 1)'(beat_in);
    return a_ext + b_ext;
  endfunction

  state_t               state_q,     state_d;
  logic [OUT_LEN-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic                 ovf_flag_q,  ovf_flag_d;
  logic [OUT_LEN-1:0]   sum_q,       sum_d;
  logic [CNT_W-1:0]     beats_q,     beats_d;
  logic                 ovf_q,       ovf_d;
  logic                 sum_valid_q, sum_valid_d;

  logic                 accept;
  logic                 close;
  logic [OUT_LEN:0]     add_full;
  logic [OUT_LEN-1:0]   acc_next;
  logic                 carry;
  logic [CNT_W-1:0]     cnt_inc;

  // ready depends on state alone so upstream never sees a valid->ready path.
  assign ready = (state_q == ST_ACC);

  assign accept   = valid && ready;
  assign add_full = add_wrap(acc_q, data);
  assign acc_next = add_full[OUT_LEN-1:0];
  assign carry    = add_full[OUT_LEN];
  assign cnt_inc  = cnt_q + 1'b1;
  // Reaching MAX_BEATS forces the frame closed regardless of last.
  assign close    = accept && (last || (cnt_inc == MAX_CNT));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_flag_d  = ovf_flag_q;
    sum_d       = sum_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    sum_valid_d = sum_valid_q;

    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d      = acc_next;
          cnt_d      = cnt_inc;
          ovf_flag_d = ovf_flag_q | carry;
        end
        if (close) begin
          // Result includes the closing beat itself.
          sum_d       = acc_next;
          beats_d     = cnt_inc;
          ovf_d       = ovf_flag_q | carry;
          sum_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // Beats are ignored here; only the result handshake moves us on.
        if (sum_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_flag_d  = 1'b0;
          sum_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_flag_q  <= 1'b0;
      sum_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_flag_q  <= ovf_flag_d;
      sum_q       <= sum_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum       = sum_q;
  assign beats     = beats_q;
  assign ovf       = ovf_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_acc_frame.sv
module tb_acc_frame;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        valid;
  logic        last;
  logic        sum_ready;

  logic        ready;
  logic [15:0] sum;
  logic        sum_valid;
  logic [4:0]  beats;
  logic        ovf;

  logic        ready8;
  logic [7:0]  sum8;
  logic        sum_valid8;
  logic [4:0]  beats8;
  logic        ovf8;

  int checks = 0;
  int errors = 0;

  acc_frame #(.LEN(8), .OUT_LEN(16), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .last(last),
    .ready(ready), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .beats(beats), .ovf(ovf)
  );

  acc_frame #(.LEN(8), .OUT_LEN(8), .MAX_BEATS(16)) dut8 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .last(last),
    .ready(ready8), .sum(sum8), .sum_valid(sum_valid8), .sum_ready(sum_ready),
    .beats(beats8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    data  = d;
    valid = 1'b1;
    last  = l;
    step();
  endtask

  task automatic idle();
    valid = 1'b0;
    last  = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b0;
    data      = '0;
    valid     = 1'b0;
    last      = 1'b0;
    sum_ready = 1'b1;
    step();
    step();

    // reset state
    check("rst_ready", ready, 1);
    check("rst_sum", sum, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_beats", beats, 0);
    check("rst_ovf", ovf, 0);

    // basic frame: 3,5,7(last)
    rst = 1'b1;
    beat(8'd3, 1'b0);
    beat(8'd5, 1'b0);
    check("basic_sv_early", sum_valid, 0);
    beat(8'd7, 1'b1);
    check("basic_sv", sum_valid, 1);
    check("basic_sum", sum, 15);
    check("basic_beats", beats, 3);
    check("basic_ovf", ovf, 0);
    check("basic_ready_done", ready, 0);
    idle();
    check("basic_sv_drop", sum_valid, 0);
    check("basic_ready_back", ready, 1);
    check("basic_sum_hold", sum, 15);

    // backpressure: 10,20(last) held 5 cycles while valid beats are offered
    sum_ready = 1'b0;
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b1);
    check("bp_sum", sum, 30);
    for (int i = 0; i < 5; i++) begin
      beat(8'd99, 1'b1);
      check("bp_hold_sv", sum_valid, 1);
      check("bp_hold_sum", sum, 30);
      check("bp_hold_ready", ready, 0);
    end
    sum_ready = 1'b1;
    idle();
    check("bp_release_sv", sum_valid, 0);
    beat(8'd5, 1'b1);
    check("bp_next_sum", sum, 5);
    check("bp_next_beats", beats, 1);
    idle();

    // forced close: 16 beats of 1, last low
    for (int i = 0; i < 15; i++) beat(8'd1, 1'b0);
    check("fc_sv_15", sum_valid, 0);
    beat(8'd1, 1'b0);
    check("fc_sv_16", sum_valid, 1);
    check("fc_sum", sum, 16);
    check("fc_beats", beats, 16);
    idle();
    beat(8'd1, 1'b1);
    check("fc_next_sum", sum, 1);
    check("fc_next_beats", beats, 1);
    idle();

    // overflow on the 8-bit instance: 200,100(last)
    beat(8'd200, 1'b0);
    beat(8'd100, 1'b1);
    check("ovf8_sum", sum8, 44);
    check("ovf8_flag", ovf8, 1);
    check("ovf16_sum", sum, 300);
    check("ovf16_flag", ovf, 0);
    idle();
    beat(8'd1, 1'b1);
    check("ovf8_next_sum", sum8, 1);
    check("ovf8_next_flag", ovf8, 0);
    idle();

    // gaps and single-beat frame
    beat(8'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("gap_sv", sum_valid, 0);
      check("gap_ready", ready, 1);
    end
    beat(8'd6, 1'b1);
    check("gap_sum", sum, 10);
    check("gap_beats", beats, 2);
    idle();
    beat(8'd9, 1'b1);
    check("single_sum", sum, 9);
    check("single_beats", beats, 1);
    idle();

    // reset mid-frame
    beat(8'd50, 1'b0);
    beat(8'd60, 1'b0);
    valid = 1'b0;
    rst   = 1'b0;
    #1;
    check("mrst_sum", sum, 0);
    check("mrst_beats", beats, 0);
    check("mrst_sv", sum_valid, 0);
    check("mrst_ovf", ovf, 0);
    check("mrst_ready", ready, 1);
    step();
    rst = 1'b1;
    beat(8'd8, 1'b1);
    check("mrst_next_sum", sum, 8);
    check("mrst_next_beats", beats, 1);
    check("mrst_next_sv", sum_valid, 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_frame.md
ACC_FRAME -- requirements
Module: acc_frame

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning input data width.
REQ-002 SHALL have parameter OUT_LEN, default 16, meaning accumulator and result width (OUT_LEN >= LEN).
REQ-003 SHALL have parameter MAX_BEATS, default 16, meaning the maximum number of beats per frame (>= 2).
REQ-004 SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset, which is asynchronous and active-low.
REQ-006 SHALL have port data, input, LEN, the upstream sum beat, unsigned.
REQ-007 SHALL have port valid, input, 1, meaning upstream beat present.
REQ-008 SHALL have port last, input, 1, meaning final beat of the frame (qualified by valid).
REQ-009 SHALL have port ready, output, 1, meaning the block accepts a beat this cycle.
REQ-010 SHALL have port sum, output, OUT_LEN, the frame total.
REQ-011 SHALL have port sum_valid, output, 1, meaning sum/beats/ovf hold a completed frame.
REQ-012 SHALL have port sum_ready, input, 1, meaning the downstream consumer accepts the result.
REQ-013 SHALL have port beats, output, clog2(MAX_BEATS+1), the number of beats in the completed frame.
REQ-014 SHALL have port ovf, output, 1, meaning the frame total wrapped beyond OUT_LEN bits.

Function
REQ-015 SHALL implement two states: ACC (collecting) and DONE (result held).
REQ-016 SHALL drive ready=1 in ACC and ready=0 in DONE, combinationally from state only (no dependence on valid).
REQ-017 SHALL accept a beat exactly when valid && ready is high at a rising clk edge.
REQ-018 SHALL, on each accepted beat, add data zero-extended to OUT_LEN to the accumulator, modulo 2^OUT_LEN.
REQ-019 SHALL set the frame's sticky overflow flag when any accepted addition produces a carry out of bit OUT_LEN-1.
REQ-020 SHALL increment the beat counter by one on each accepted beat.
REQ-021 SHALL close the frame on an accepted beat with last=1, or on the accepted beat that brings the count to MAX_BEATS (forced close, last ignored).
REQ-022 SHALL, on close, load sum, beats and ovf including the closing beat and enter DONE, so that sum_valid=1 on the cycle after the closing beat (1-cycle latency).
REQ-023 SHALL hold sum, beats, ovf and sum_valid stable in DONE until sum_ready=1 at a clock edge.
REQ-024 SHALL, on sum_valid && sum_ready, return to ACC with the accumulator, counter and overflow flag cleared, and sum_valid=0 on the next cycle.
REQ-025 SHALL ignore data, valid and last while in DONE (no beat is consumed).
REQ-026 SHALL treat a single accepted beat with last=1 as a complete one-beat frame (beats=1, sum=data).
REQ-027 SHALL leave accumulator contents unchanged on cycles without an accepted beat; idle gaps inside a frame are legal.
REQ-028 SHALL hold sum, beats and ovf at their previous values in ACC (only sum_valid=0 qualifies them).

Reset
REQ-029 SHALL, while rst=0, immediately force state=ACC, accumulator=0, counter=0, overflow flag=0, sum=0, beats=0, ovf=0, sum_valid=0, and ready=1 (after reset state is established).
REQ-030 SHALL discard any partial frame or held result when reset asserts mid-operation, without emitting it.
REQ-031 SHALL resume accepting beats on the first rising clk edge after rst returns to 1.

Verification
REQ-032 SHALL pass test "basic frame": beats 3,5,7 with last on 7, sum_ready=1 -> sum=15, beats=3, ovf=0, sum_valid for 1 cycle, asserted one cycle after the beat with 7.
REQ-033 SHALL pass test "backpressure": frame 10,20(last) with sum_ready=0 for 5 cycles -> sum=30 held; ready=0 and valid beats not consumed during the hold; the next frame starts after sum_ready=1.
REQ-034 SHALL pass test "forced close": 16 beats of 1 with last=0 (MAX_BEATS=16) -> sum=16, beats=16 after the 16th beat; the 17th beat starts a new frame.
REQ-035 SHALL pass test "overflow": OUT_LEN=8, LEN=8, beats 200,100(last) -> sum=44, ovf=1; the next frame 1(last) -> sum=1, ovf=0.
REQ-036 SHALL pass test "gaps and single beat": 4, idle 3 cycles, 6(last), then 9(last) -> first sum=10, beats=2; second sum=9, beats=1.
REQ-037 SHALL pass test "reset mid-frame": 2 beats accepted, rst=0 asynchronously -> all outputs 0 immediately; after release, frame 8(last) -> sum=8, beats=1.
